multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multicycle RV32I main controller FSM; successor to the single-cycle main decoder.
- Sequences each instruction over several cycles through one shared ALU and unified memory.
- Adds lui/auipc/jalr, memory wait-states via a ready handshake, a bounded wait timeout, and a trap state for illegal opcodes.
- Sits between the instruction register (op field) and the multicycle datapath.

Parameters:
- MAX_WAIT, 15, maximum consecutive cycles a memory access may wait for mem_ready before bus error (1..2^WAIT_W-1).
- WAIT_W, 4, width of the wait counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- op  input  7  opcode from instruction register.
- mem_ready  input  1  memory completes current access this cycle.
- mem_req  output  1  memory access in progress (FETCH, MEMREAD, MEMWRITE).
- PCWrite  output  1  unconditional PC load.
- Branch  output  1  conditional PC load; datapath qualifies it with the comparison.
- AdrSrc  output  1  0 = PC, 1 = ALUOut as memory address.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  load IR and OldPC.
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
- ALUSrcB  output  2  00 rs2, 01 ImmExt, 10 constant 4.
- ALUOp  output  2  00 add, 01 branch compare, 10 funct decode.
- ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U. Combinational from op in every state; 000 for unknown op.
- RegWrite  output  1  register file write.
- illegal  output  1  sticky: trap taken on an unknown opcode.
- bus_err  output  1  sticky: trap taken on a wait timeout.

Behaviour:
- Reset: state = FETCH, wait counter = 0, illegal = 0, bus_err = 0.
- All strobes are Moore outputs of state, except PCWrite, IRWrite and MemWrite, which are also gated as stated below. Unlisted outputs are 0 in a state.
- Per-state outputs and transitions:
  - FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite = PCWrite = mem_ready. Go to DECODE on mem_ready, else hold.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes branch/jal/auipc target). Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALRADR
    - 0110111 → LUI
    - 0010111 → ALUWB
    - other → TRAP, setting illegal.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Go to MEMWB on mem_ready.
  - MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
  - MEMWRITE: mem_req=1, AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready. Go to FETCH on mem_ready.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
  - LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00. Go to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Go to FETCH.
  - JALRADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 (target into ALUOut). Go to JAL.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 (PC ← target). Go to ALUWB, which writes OldPC+4. Clearing target bit 0 for jalr is the datapath's job.
  - TRAP: all strobes 0, mem_req=0. Stays in TRAP until reset.
- Wait counter:
  - Increments each cycle the FSM is in a mem_req state with mem_ready=0.
  - Clears on mem_ready or on leaving the state.
  - When the counter equals MAX_WAIT and mem_ready=0: go to TRAP and set bus_err. Strobes are suppressed that cycle.
  - mem_ready=1 in the same cycle the counter reaches MAX_WAIT: the access completes and no error is raised.
- Latency in cycles, with zero wait states:
  - lw 5; sw 4; R/I/lui 4; auipc 3; branch 3; jal 4; jalr 5.
- Reset asserted in any state, including mid-wait or TRAP: next state is FETCH, counter cleared, flags cleared. Outputs during the reset cycle reflect the pre-reset state; memory must tolerate an aborted access.

Optional Feature:
- Macro: INSTRET_EN.
- When defined: adds output port instret, 32 bits.
  - Resets to 0.
  - Increments by 1 on every transition into FETCH from a non-TRAP state.
  - Wraps from 0xFFFFFFFF to 0.
- When undefined: port and counter are absent; everything else is identical.

Test Plan:
- add (op 0110011), mem_ready tied 1 → states FETCH, DECODE, EXECR, ALUWB, FETCH. RegWrite=1 only in cycle 4. IRWrite and PCWrite=1 only in cycle 1.
- lw (op 0000011), mem_ready low for 3 cycles in MEMREAD → MEMREAD held 4 cycles, AdrSrc=1 throughout, MEMWB follows. Total 8 cycles, bus_err=0.
- sw (op 0100011), mem_ready never asserted, MAX_WAIT=15 → MemWrite=1 for 15 cycles, then TRAP with bus_err=1 and all strobes 0. reset → FETCH, bus_err=0.
- jalr (op 1100111) → states JALRADR (ALUSrcA=10, ALUSrcB=01), then JAL (PCWrite=1, ALUSrcA=01, ALUSrcB=10), then ALUWB (RegWrite=1).
- op 1111111 → DECODE then TRAP, illegal=1, no RegWrite/MemWrite for 20 further cycles. lui (op 0110111) after reset: ImmSrc=100, ALUSrcA=11 in LUI state.
- INSTRET_EN defined: 3 back-to-back auipc instructions → instret=3 after cycle 9. Preload 0xFFFFFFFF, retire 1 → instret=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32I main controller: sequences fetch/decode/execute through a shared ALU and memory.
// Optional retired-instruction counter port `instret` is built when INSTRET_EN is defined.
module multicycle_controller #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        PCWrite,
  output logic        Branch,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [2:0]  ImmSrc,
  output logic        RegWrite,
  output logic        illegal,
`ifdef INSTRET_EN
  output logic [31:0] instret,
`endif
  output logic        bus_err
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_LUI, S_ALUWB, S_BRANCH, S_JALRADR, S_JAL, S_TRAP
  } state_t;

  // Raw per-state strobes; fetch/jal/write strobes are qualified by mem_ready and timeout below.
  typedef struct packed {
    logic       mem_req;
    logic       fetch;
    logic       jal_pc;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  state_t            state_q;
  state_t            state_nxt;
  ctrl_t             ctrl_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout;
  logic              illegal_q;
  logic              bus_err_q;

  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.fetch      = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR, S_JALRADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_req   = 1'b1;
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      S_EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_LUI: begin
        c.alu_src_a = 2'b11;
        c.alu_src_b = 2'b01;
      end
      S_ALUWB: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.jal_pc    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic state_t next_of(input state_t s, input logic [6:0] o,
                                     input logic rdy, input logic to);
    state_t n;
    n = s;
    case (s)
      S_FETCH: n = rdy ? S_DECODE : (to ? S_TRAP : S_FETCH);
      S_DECODE: begin
        case (o)
          7'b0000011, 7'b0100011: n = S_MEMADR;
          7'b0110011:             n = S_EXECR;
          7'b0010011:             n = S_EXECI;
          7'b1100011:             n = S_BRANCH;
          7'b1101111:             n = S_JAL;
          7'b1100111:             n = S_JALRADR;
          7'b0110111:             n = S_LUI;
          7'b0010111:             n = S_ALUWB;
          default:                n = S_TRAP;
        endcase
      end
      S_MEMADR:   n = o[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  n = rdy ? S_MEMWB : (to ? S_TRAP : S_MEMREAD);
      S_MEMWRITE: n = rdy ? S_FETCH : (to ? S_TRAP : S_MEMWRITE);
      S_MEMWB, S_ALUWB, S_BRANCH: n = S_FETCH;
      S_EXECR, S_EXECI, S_LUI:    n = S_ALUWB;
      S_JALRADR:  n = S_JAL;
      S_JAL:      n = S_ALUWB;
      default:    n = S_TRAP;
    endcase
    return n;
  endfunction

  // A ready in the same cycle the counter hits MAX_WAIT still completes the access.
  assign timeout   = ctrl_q.mem_req && !mem_ready && (wait_cnt == WAIT_W'(MAX_WAIT));
  assign state_nxt = next_of(state_q, op, mem_ready, timeout);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ctrl_q    <= ctrl_of(S_FETCH);
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      ctrl_q  <= ctrl_of(state_nxt);
      if (ctrl_q.mem_req && !mem_ready && !timeout)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (state_q == S_DECODE && state_nxt == S_TRAP)
        illegal_q <= 1'b1;
      if (timeout)
        bus_err_q <= 1'b1;
    end
  end

`ifdef INSTRET_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk) begin
    if (reset)
      instret_q <= '0;
    else if (state_nxt == S_FETCH && state_q != S_FETCH && state_q != S_TRAP)
      instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`endif

  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: ImmSrc = 3'b000;
      7'b0100011:                         ImmSrc = 3'b001;
      7'b1100011:                         ImmSrc = 3'b010;
      7'b1101111:                         ImmSrc = 3'b011;
      7'b0110111, 7'b0010111:             ImmSrc = 3'b100;
      default:                            ImmSrc = 3'b000;
    endcase
  end

  assign mem_req   = ctrl_q.mem_req;
  assign PCWrite   = ctrl_q.jal_pc | (ctrl_q.fetch & mem_ready);
  assign IRWrite   = ctrl_q.fetch & mem_ready;
  assign MemWrite  = ctrl_q.mem_write & ~timeout;
  assign Branch    = ctrl_q.branch;
  assign AdrSrc    = ctrl_q.adr_src;
  assign RegWrite  = ctrl_q.reg_write;
  assign ResultSrc = ctrl_q.result_src;
  assign ALUSrcA   = ctrl_q.alu_src_a;
  assign ALUSrcB   = ctrl_q.alu_src_b;
  assign ALUOp     = ctrl_q.alu_op;
  assign illegal   = illegal_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected strobes queued with stimulus.
module tb_multicycle_controller;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  logic        clk;
  logic        reset;
  logic [6:0]  op;
  logic        mem_ready;
  logic        mem_req, PCWrite, Branch, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic        illegal, bus_err;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0]  ImmSrc;
`ifdef INSTRET_EN
  logic [31:0] instret;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic exp_ill = 1'b0;
  logic exp_be  = 1'b0;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic        rdy;
    logic [19:0] exp;
  } step_t;

  step_t sb[$];
  int    step_no = 0;

  multicycle_controller #(.MAX_WAIT(15), .WAIT_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .PCWrite(PCWrite), .Branch(Branch), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .illegal(illegal),
`ifdef INSTRET_EN
    .instret(instret),
`endif
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, required completion");
    $fatal(1);
  end

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    if (o == OP_SW) return 3'b001;
    if (o == OP_BEQ) return 3'b010;
    if (o == OP_JAL) return 3'b011;
    if (o == OP_LUI || o == OP_AUIPC) return 3'b100;
    return 3'b000;
  endfunction

  // {mem_req,PCWrite,Branch,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,illegal,bus_err,ImmSrc}
  function automatic logic [19:0] exp_vec(input string s, input logic [6:0] o,
                                          input logic rdy, input logic to,
                                          input logic ill, input logic be);
    logic mr, pcw, br, adr, mw, irw, rw;
    logic [1:0] rs, a, b, alu;
    {mr, pcw, br, adr, mw, irw, rw} = '0;
    {rs, a, b, alu} = '0;
    if (s == "FETCH") begin mr = 1; b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
    else if (s == "DECODE") begin a = 2'b01; b = 2'b01; end
    else if (s == "MEMADR" || s == "JALRADR") begin a = 2'b10; b = 2'b01; end
    else if (s == "MEMREAD") begin mr = 1; adr = 1; end
    else if (s == "MEMWB") begin rs = 2'b01; rw = 1; end
    else if (s == "MEMWRITE") begin mr = 1; adr = 1; mw = !to; end
    else if (s == "EXECR") begin a = 2'b10; alu = 2'b10; end
    else if (s == "EXECI") begin a = 2'b10; b = 2'b01; alu = 2'b10; end
    else if (s == "LUI") begin a = 2'b11; b = 2'b01; end
    else if (s == "ALUWB") rw = 1;
    else if (s == "BRANCH") begin a = 2'b10; alu = 2'b01; br = 1; end
    else if (s == "JAL") begin a = 2'b01; b = 2'b10; pcw = 1; end
    return {mr, pcw, br, adr, mw, irw, rw, rs, a, b, alu, ill, be, imm_of(o)};
  endfunction

  task automatic push(input string s, input logic [6:0] o, input logic rdy, input logic to = 1'b0);
    step_t e;
    e.name = s;
    e.op   = o;
    e.rdy  = rdy;
    e.exp  = exp_vec(s, o, rdy, to, exp_ill, exp_be);
    sb.push_back(e);
  endtask

  task automatic push_insn(input logic [6:0] o);
    push("FETCH", o, 1'b1);
    push("DECODE", o, 1'b1);
    if (o == OP_ADD) begin push("EXECR", o, 1'b1); push("ALUWB", o, 1'b1); end
    if (o == OP_ADDI) begin push("EXECI", o, 1'b1); push("ALUWB", o, 1'b1); end
    if (o == OP_LUI) begin push("LUI", o, 1'b1); push("ALUWB", o, 1'b1); end
    if (o == OP_AUIPC) push("ALUWB", o, 1'b1);
    if (o == OP_BEQ) push("BRANCH", o, 1'b1);
    if (o == OP_JAL) begin push("JAL", o, 1'b1); push("ALUWB", o, 1'b1); end
    if (o == OP_JALR) begin push("JALRADR", o, 1'b1); push("JAL", o, 1'b1); push("ALUWB", o, 1'b1); end
  endtask

  // Drive the next queued cycle and return what the DUT shows mid-cycle.
  task automatic drive_next(output logic [19:0] got, output step_t e);
    e = sb.pop_front();
    op = e.op;
    mem_ready = e.rdy;
    step_no++;
    #2;
    got = {mem_req, PCWrite, Branch, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal, bus_err, ImmSrc};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_ill = 1'b0;
    exp_be = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] got; step_t e;
    do_reset();
    push("FETCH", OP_ADD, 1'b0);
    push("FETCH", OP_ADD, 1'b0);
    while (sb.size() > 0) begin
      drive_next(got, e);
      tests_run++;
      if (got !== e.exp) begin
        tests_failed++;
        $display("FAIL reset/%s step %0d: got %h required %h", e.name, step_no, got, e.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_alu_ops();
    logic [19:0] got; step_t e;
    do_reset();
    push_insn(OP_ADD);
    push_insn(OP_LUI);
    push_insn(OP_JALR);
    push("FETCH", OP_ADD, 1'b0);
    while (sb.size() > 0) begin
      drive_next(got, e);
      tests_run++;
      if (got !== e.exp) begin
        tests_failed++;
        $display("FAIL alu_ops/%s step %0d: got %h required %h", e.name, step_no, got, e.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_wait();
    logic [19:0] got; step_t e;
    do_reset();
    push("FETCH", OP_LW, 1'b1);
    push("DECODE", OP_LW, 1'b1);
    push("MEMADR", OP_LW, 1'b1);
    for (int i = 0; i < 3; i++) push("MEMREAD", OP_LW, 1'b0);
    push("MEMREAD", OP_LW, 1'b1);
    push("MEMWB", OP_LW, 1'b1);
    push("FETCH", OP_LW, 1'b0);
    while (sb.size() > 0) begin
      drive_next(got, e);
      tests_run++;
      if (got !== e.exp) begin
        tests_failed++;
        $display("FAIL load_wait/%s step %0d: got %h required %h", e.name, step_no, got, e.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store_timeout();
    logic [19:0] got; step_t e;
    do_reset();
    push("FETCH", OP_SW, 1'b1);
    push("DECODE", OP_SW, 1'b1);
    push("MEMADR", OP_SW, 1'b1);
    for (int i = 0; i < 15; i++) push("MEMWRITE", OP_SW, 1'b0);
    push("MEMWRITE", OP_SW, 1'b0, 1'b1);
    exp_be = 1'b1;
    for (int i = 0; i < 3; i++) push("TRAP", OP_SW, 1'b0);
    while (sb.size() > 0) begin
      drive_next(got, e);
      tests_run++;
      if (got !== e.exp) begin
        tests_failed++;
        $display("FAIL store_timeout/%s step %0d: got %h required %h", e.name, step_no, got, e.exp);
      end
      @(negedge clk);
    end
    do_reset();
    push("FETCH", OP_SW, 1'b0);
    drive_next(got, e);
    tests_run++;
    if (got !== e.exp) begin
      tests_failed++;
      $display("FAIL store_timeout/after_reset: got %h required %h", got, e.exp);
    end
    @(negedge clk);
  endtask

  task automatic test_ready_at_limit();
    logic [19:0] got; step_t e;
    do_reset();
    push("FETCH", OP_SW, 1'b1);
    push("DECODE", OP_SW, 1'b1);
    push("MEMADR", OP_SW, 1'b1);
    for (int i = 0; i < 15; i++) push("MEMWRITE", OP_SW, 1'b0);
    push("MEMWRITE", OP_SW, 1'b1);
    push("FETCH", OP_ADD, 1'b0);
    while (sb.size() > 0) begin
      drive_next(got, e);
      tests_run++;
      if (got !== e.exp) begin
        tests_failed++;
        $display("FAIL ready_at_limit/%s step %0d: got %h required %h", e.name, step_no, got, e.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic [19:0] got; step_t e;
    do_reset();
    push("FETCH", OP_BAD, 1'b1);
    push("DECODE", OP_BAD, 1'b1);
    exp_ill = 1'b1;
    for (int i = 0; i < 20; i++) push("TRAP", OP_BAD, 1'($urandom_range(0, 1)));
    while (sb.size() > 0) begin
      drive_next(got, e);
      tests_run++;
      if (got !== e.exp) begin
        tests_failed++;
        $display("FAIL illegal/%s step %0d: got %h required %h", e.name, step_no, got, e.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] got; step_t e;
    do_reset();
    push_insn(OP_AUIPC);
    push_insn(OP_AUIPC);
    push_insn(OP_AUIPC);
    push_insn(OP_BEQ);
    push_insn(OP_JAL);
    push_insn(OP_ADDI);
    push("FETCH", OP_ADDI, 1'b0);
    while (sb.size() > 0) begin
      drive_next(got, e);
      tests_run++;
      if (got !== e.exp) begin
        tests_failed++;
        $display("FAIL back_to_back/%s step %0d: got %h required %h", e.name, step_no, got, e.exp);
      end
      @(negedge clk);
    end
  endtask

`ifdef INSTRET_EN
  task automatic test_instret();
    logic [19:0] got; step_t e;
    do_reset();
    for (int i = 0; i < 3; i++) push_insn(OP_AUIPC);
    while (sb.size() > 0) begin
      drive_next(got, e);
      @(negedge clk);
    end
    tests_run++;
    if (instret !== 32'd3) begin
      tests_failed++;
      $display("FAIL instret_count: got %0d required 3", instret);
    end
    force dut.instret_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.instret_q;
    push_insn(OP_AUIPC);
    while (sb.size() > 0) begin
      drive_next(got, e);
      @(negedge clk);
    end
    tests_run++;
    if (instret !== 32'd0) begin
      tests_failed++;
      $display("FAIL instret_wrap: got %h required 00000000", instret);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    op = OP_ADD;
    mem_ready = 1'b0;
    test_reset();
    test_alu_ops();
    test_load_wait();
    test_store_timeout();
    test_ready_at_limit();
    test_illegal();
    test_back_to_back();
`ifdef INSTRET_EN
    test_instret();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
